fixed_to_float_arbiter: RTL and testbench
=========================================

FIXED_TO_FLOAT_ARBITER -- requirements
Module: fixed_to_float_arbiter

Interface
REQ-001 Parameter: p_REQUESTERS, default 4, number of requester ports (2..8).
REQ-002 Parameter: p_CVT_LATENCY, default 2, cycles from word presented to the converter until the float result is valid (>=2).
REQ-003 i_CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 i_RST_N  input  1  reset, asynchronous, active-low.
REQ-005 i_REQ_VALID  input  p_REQUESTERS  per-requester request valid.
REQ-006 i_REQ_WORD  input  32*p_REQUESTERS  signed fixed-point words; requester i occupies bits [32i+31:32i].
REQ-007 o_REQ_READY  output  p_REQUESTERS  per-requester accept; at most one bit high per cycle.
REQ-008 i_HOLD  input  1  when high, no new grants; in-flight conversions complete.
REQ-009 o_CVT_WORD  output  32  word driven to the shared fixed-to-float converter.
REQ-010 i_CVT_RESULT  input  32  converter float result.
REQ-011 i_CVT_INVALID  input  1  converter zero/invalid flag, valid p_CVT_LATENCY-1 cycles after the word is presented.
REQ-012 o_RSP_VALID  output  p_REQUESTERS  one-hot response strobe to the owning requester.
REQ-013 o_RSP_WORD  output  32  float result shared by all requesters.
REQ-014 o_RSP_INVALID  output  1  invalid flag aligned with o_RSP_VALID.
REQ-015 o_IDLE  output  1  high when no conversion is in flight.

Function
REQ-016 Arbitration is round-robin: the search starts at pointer r_PTR and the first requester with i_REQ_VALID high is granted; o_REQ_READY is combinational from i_REQ_VALID, r_PTR and i_HOLD.
REQ-017 A transfer occurs when i_REQ_VALID[i] & o_REQ_READY[i]; one transfer at most per cycle; sustained throughput is one word per cycle.
REQ-018 On a transfer from requester g, r_PTR becomes (g+1) mod p_REQUESTERS on the next edge; without a transfer r_PTR holds.
REQ-019 Requesters hold i_REQ_WORD stable while valid and not ready; the arbiter does not register request words.
REQ-020 o_CVT_WORD equals the granted requester's word during a transfer cycle, else 32'h0.
REQ-021 A tag pipeline of p_CVT_LATENCY stages carries {valid, requester index}; stage 0 loads on every edge (valid=transfer), each later stage loads from the previous one.
REQ-022 The invalid flag is sampled from i_CVT_INVALID when the tag reaches stage p_CVT_LATENCY-1 and is carried one more stage with the tag.
REQ-023 Transfer at edge-cycle T -> o_RSP_VALID[g] high during cycle T+p_CVT_LATENCY for exactly one cycle; o_RSP_WORD = i_CVT_RESULT (combinational pass-through) and o_RSP_INVALID = carried flag in that cycle.
REQ-024 o_RSP_VALID is decoded from the final tag stage; all bits are low when that stage is invalid; o_RSP_INVALID is 0 when no response is valid.
REQ-025 Responses are not back-pressured; requesters accept them when strobed.
REQ-026 i_HOLD high forces o_REQ_READY to 0 the same cycle; pointer is frozen; in-flight responses still emerge.
REQ-027 o_IDLE = no valid bit set in any tag stage.
REQ-028 A requester may issue back-to-back transfers only when it is the sole valid requester; otherwise round-robin interleaves.

Reset
REQ-029 While i_RST_N low: r_PTR=0, all tag valid bits 0, carried invalid flag 0; hence o_RSP_VALID=0, o_RSP_INVALID=0, o_IDLE=1, o_REQ_READY=0 and o_CVT_WORD=0 regardless of inputs.
REQ-030 Reset asserted mid-operation discards every in-flight tag; no response strobe occurs for conversions accepted before reset, even if the converter later produces results.
REQ-031 First grant after deassertion starts search at requester 0.

Verification
REQ-032 Single request: requester 2 sends 32'h00000005, stub converter returns word^32'hA5A5A5A5 after 2 cycles -> o_RSP_VALID=4'b0100 exactly 2 cycles after transfer, o_RSP_WORD=32'hA5A5A5A0.
REQ-033 All 4 valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; responses strobed in the same order, one per cycle.
REQ-034 Zero word 32'h0 from requester 1 with stub asserting i_CVT_INVALID at latency-1 -> o_RSP_INVALID=1 with o_RSP_VALID=4'b0010; neighbouring nonzero responses have o_RSP_INVALID=0.
REQ-035 i_HOLD raised with 2 conversions in flight -> o_REQ_READY=0 immediately, both responses still delivered, o_IDLE rises after the last, r_PTR unchanged on release.
REQ-036 i_RST_N pulsed low one cycle after two transfers -> no o_RSP_VALID strobe for either; o_IDLE=1; next grant goes to lowest valid index.
REQ-037 p_CVT_LATENCY=4 rerun of REQ-033 -> each response appears exactly 4 cycles after its transfer.

Source files
------------

// File: rtl/fixed_to_float_arbiter_if.sv
// Bundle of request, converter and response signals between the requesters,
// the shared fixed-to-float converter and the round-robin arbiter.
interface fixed_to_float_arbiter_if #(
  parameter int p_REQUESTERS = 4
);
  // Request handshake: a word moves from requester i when i_REQ_VALID[i] and
  // o_REQ_READY[i] are both high on a rising edge. A requester keeps its word
  // stable while valid and not ready. Responses are strobes with no ready.
  logic [p_REQUESTERS-1:0]    i_REQ_VALID;
  logic [32*p_REQUESTERS-1:0] i_REQ_WORD;
  logic [p_REQUESTERS-1:0]    o_REQ_READY;
  logic                       i_HOLD;
  logic [31:0]                o_CVT_WORD;
  logic [31:0]                i_CVT_RESULT;
  logic                       i_CVT_INVALID;
  logic [p_REQUESTERS-1:0]    o_RSP_VALID;
  logic [31:0]                o_RSP_WORD;
  logic                       o_RSP_INVALID;
  logic                       o_IDLE;

  modport slave (
    input  i_REQ_VALID, i_REQ_WORD, i_HOLD, i_CVT_RESULT, i_CVT_INVALID,
    output o_REQ_READY, o_CVT_WORD, o_RSP_VALID, o_RSP_WORD, o_RSP_INVALID, o_IDLE
  );

  modport master (
    output i_REQ_VALID, i_REQ_WORD, i_HOLD, i_CVT_RESULT, i_CVT_INVALID,
    input  o_REQ_READY, o_CVT_WORD, o_RSP_VALID, o_RSP_WORD, o_RSP_INVALID, o_IDLE
  );
endinterface

// File: rtl/fixed_to_float_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-to-float converter among
// several requesters; a tag pipeline routes each result back to its owner.
module fixed_to_float_arbiter #(
  parameter int p_REQUESTERS  = 4,
  parameter int p_CVT_LATENCY = 2
) (
  input  logic                           i_CLK,
  input  logic                           i_RST_N,
  fixed_to_float_arbiter_if.slave        bus
);

  localparam int IDX_W = (p_REQUESTERS > 1) ? $clog2(p_REQUESTERS) : 1;
  localparam int LAT   = p_CVT_LATENCY;

  typedef logic [IDX_W-1:0] idx_t;

  idx_t           r_PTR;
  logic [LAT-1:0] r_tag_vld;
  idx_t           r_tag_idx [LAT];
  logic           r_inv;

  logic grant_found;
  idx_t grant_idx;
  logic transfer;

  // Search starts at r_PTR and wraps; first valid requester wins.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < p_REQUESTERS; k++) begin
      cand = (int'(r_PTR) + k) % p_REQUESTERS;
      if (!grant_found && bus.i_REQ_VALID[cand]) begin
        grant_found = 1'b1;
        grant_idx   = idx_t'(cand);
      end
    end
  end

  // Reset also gates the grant so nothing is accepted while rst_n is low.
  assign transfer = grant_found & ~bus.i_HOLD & i_RST_N;

  always_comb begin
    bus.o_REQ_READY = '0;
    for (int i = 0; i < p_REQUESTERS; i++) begin
      bus.o_REQ_READY[i] = transfer && (grant_idx == idx_t'(i));
    end
    bus.o_CVT_WORD = transfer ? bus.i_REQ_WORD[int'(grant_idx)*32 +: 32] : 32'h0;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_PTR     <= '0;
      r_tag_vld <= '0;
      r_inv     <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        r_tag_idx[k] <= '0;
      end
    end else begin
      if (transfer) begin
        r_PTR <= (int'(grant_idx) == p_REQUESTERS - 1) ? idx_t'(0) : grant_idx + 1'b1;
      end
      r_tag_vld    <= {r_tag_vld[LAT-2:0], transfer};
      r_tag_idx[0] <= grant_idx;
      for (int k = 1; k < LAT; k++) begin
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
      // Flag is valid one cycle before the result; capture it as the tag enters the last stage.
      r_inv <= r_tag_vld[LAT-2] & bus.i_CVT_INVALID;
    end
  end

  always_comb begin
    bus.o_RSP_VALID = '0;
    for (int i = 0; i < p_REQUESTERS; i++) begin
      bus.o_RSP_VALID[i] = r_tag_vld[LAT-1] && (r_tag_idx[LAT-1] == idx_t'(i));
    end
    bus.o_RSP_WORD    = bus.i_CVT_RESULT;
    bus.o_RSP_INVALID = r_tag_vld[LAT-1] & r_inv;
    bus.o_IDLE        = ~|r_tag_vld;
  end

endmodule

// File: tb/tb_fixed_to_float_arbiter.sv
// Directed bench: two arbiters (converter latency 2 and 4) share one stimulus
// stream; each has its own converter stub returning word ^ 32'hA5A5A5A5.
module tb_fixed_to_float_arbiter;
  localparam int N = 4;
  localparam logic [31:0] XK = 32'hA5A5A5A5;

  logic i_CLK = 1'b0;
  logic i_RST_N = 1'b0;
  always #5 i_CLK = ~i_CLK;

  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_word;
  logic            hold;

  int n_assert = 0;
  int n_fail   = 0;

  fixed_to_float_arbiter_if #(.p_REQUESTERS(N)) bus2 ();
  fixed_to_float_arbiter_if #(.p_REQUESTERS(N)) bus4 ();

  fixed_to_float_arbiter #(.p_REQUESTERS(N), .p_CVT_LATENCY(2)) dut2 (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .bus(bus2.slave));
  fixed_to_float_arbiter #(.p_REQUESTERS(N), .p_CVT_LATENCY(4)) dut4 (
    .i_CLK(i_CLK), .i_RST_N(i_RST_N), .bus(bus4.slave));

  assign bus2.i_REQ_VALID = req_valid;
  assign bus2.i_REQ_WORD  = req_word;
  assign bus2.i_HOLD      = hold;
  assign bus4.i_REQ_VALID = req_valid;
  assign bus4.i_REQ_WORD  = req_word;
  assign bus4.i_HOLD      = hold;

  // Converter stubs: history of presented words and whether a transfer happened.
  logic [31:0] h2_w [2];
  logic        h2_v [2];
  logic [31:0] h4_w [4];
  logic        h4_v [4];

  always @(posedge i_CLK) begin
    h2_w[0] <= bus2.o_CVT_WORD;
    h2_v[0] <= |bus2.o_REQ_READY;
    h2_w[1] <= h2_w[0];
    h2_v[1] <= h2_v[0];
    h4_w[0] <= bus4.o_CVT_WORD;
    h4_v[0] <= |bus4.o_REQ_READY;
    for (int k = 1; k < 4; k++) begin
      h4_w[k] <= h4_w[k-1];
      h4_v[k] <= h4_v[k-1];
    end
  end

  assign bus2.i_CVT_RESULT  = h2_w[1] ^ XK;
  assign bus2.i_CVT_INVALID = h2_v[0] && (h2_w[0] == 32'h0);
  assign bus4.i_CVT_RESULT  = h4_w[3] ^ XK;
  assign bus4.i_CVT_INVALID = h4_v[2] && (h4_w[2] == 32'h0);

  logic [31:0] w [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, apply inputs, then settle before checking.
  task automatic cyc(input logic [N-1:0] v, input logic h);
    @(posedge i_CLK);
    #2;
    req_valid = v;
    hold      = h;
    #1;
  endtask

  task automatic load_words();
    for (int i = 0; i < N; i++) req_word[32*i +: 32] = w[i];
  endtask

  initial begin
    logic [3:0] e2, e4;
    w[0] = 32'h1000_0001;
    w[1] = 32'h2000_0002;
    w[2] = 32'h0000_0005;
    w[3] = 32'h4000_0004;
    load_words();
    req_valid = '1;
    hold      = 1'b0;

    // Reset: outputs forced quiet even with every requester valid.
    repeat (3) @(posedge i_CLK);
    #3;
    chk("rst_ready", 32'(bus2.o_REQ_READY), 32'h0);
    chk("rst_cvt_word", bus2.o_CVT_WORD, 32'h0);
    chk("rst_rsp_valid", 32'(bus2.o_RSP_VALID), 32'h0);
    chk("rst_rsp_inv", 32'(bus2.o_RSP_INVALID), 32'h0);
    chk("rst_idle2", 32'(bus2.o_IDLE), 32'h1);
    chk("rst_idle4", 32'(bus4.o_IDLE), 32'h1);
    req_valid = '0;
    #1 i_RST_N = 1'b1;

    // Single request from requester 2.
    cyc(4'b0100, 1'b0);
    chk("single_ready", 32'(bus2.o_REQ_READY), 32'h4);
    chk("single_cvt_word", bus2.o_CVT_WORD, 32'h0000_0005);
    chk("single_idle_before", 32'(bus2.o_IDLE), 32'h1);
    cyc(4'b0000, 1'b0);
    chk("single_rsp_t1", 32'(bus2.o_RSP_VALID), 32'h0);
    chk("single_busy", 32'(bus2.o_IDLE), 32'h0);
    chk("single_cvt_idle", bus2.o_CVT_WORD, 32'h0);
    cyc(4'b0000, 1'b0);
    chk("single_rsp_t2", 32'(bus2.o_RSP_VALID), 32'h4);
    chk("single_rsp_word", bus2.o_RSP_WORD, 32'hA5A5_A5A0);
    chk("single_rsp_inv", 32'(bus2.o_RSP_INVALID), 32'h0);
    cyc(4'b0000, 1'b0);
    chk("single_rsp_t3", 32'(bus2.o_RSP_VALID), 32'h0);
    cyc(4'b0000, 1'b0);
    chk("single_lat4_rsp", 32'(bus4.o_RSP_VALID), 32'h4);
    chk("single_lat4_word", bus4.o_RSP_WORD, 32'hA5A5_A5A0);
    chk("single_idle_after", 32'(bus2.o_IDLE), 32'h1);
    cyc(4'b0000, 1'b0);
    chk("single_idle4_after", 32'(bus4.o_IDLE), 32'h1);

    // Fresh reset so the all-valid run starts at requester 0.
    i_RST_N = 1'b0;
    #1 i_RST_N = 1'b1;

    // All four valid for 8 cycles: grants 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 12; c++) begin
      cyc((c < 8) ? 4'b1111 : 4'b0000, 1'b0);
      if (c < 8) begin
        chk($sformatf("rr_ready_c%0d", c), 32'(bus2.o_REQ_READY), 32'(4'b0001 << (c % 4)));
        chk($sformatf("rr_cvt_c%0d", c), bus2.o_CVT_WORD, w[c % 4]);
      end
      e2 = (c >= 2 && c < 10) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
      e4 = (c >= 4 && c < 12) ? (4'b0001 << ((c - 4) % 4)) : 4'b0000;
      chk($sformatf("rr_rsp2_c%0d", c), 32'(bus2.o_RSP_VALID), 32'(e2));
      chk($sformatf("rr_rsp4_c%0d", c), 32'(bus4.o_RSP_VALID), 32'(e4));
      if (e2 != 4'b0000)
        chk($sformatf("rr_word2_c%0d", c), bus2.o_RSP_WORD, w[(c - 2) % 4] ^ XK);
      if (e4 != 4'b0000)
        chk($sformatf("rr_word4_c%0d", c), bus4.o_RSP_WORD, w[(c - 4) % 4] ^ XK);
    end

    // Zero word from requester 1 between two nonzero words.
    w[1] = 32'h0;
    load_words();
    cyc(4'b0111, 1'b0);
    chk("zero_ready0", 32'(bus2.o_REQ_READY), 32'h1);
    cyc(4'b0110, 1'b0);
    chk("zero_ready1", 32'(bus2.o_REQ_READY), 32'h2);
    chk("zero_cvt", bus2.o_CVT_WORD, 32'h0);
    cyc(4'b0100, 1'b0);
    chk("zero_ready2", 32'(bus2.o_REQ_READY), 32'h4);
    chk("zero_rsp_a", 32'(bus2.o_RSP_VALID), 32'h1);
    chk("zero_inv_a", 32'(bus2.o_RSP_INVALID), 32'h0);
    cyc(4'b0000, 1'b0);
    chk("zero_rsp_b", 32'(bus2.o_RSP_VALID), 32'h2);
    chk("zero_inv_b", 32'(bus2.o_RSP_INVALID), 32'h1);
    cyc(4'b0000, 1'b0);
    chk("zero_rsp_c", 32'(bus2.o_RSP_VALID), 32'h4);
    chk("zero_inv_c", 32'(bus2.o_RSP_INVALID), 32'h0);
    chk("zero_lat4_inv_a", 32'(bus4.o_RSP_INVALID), 32'h0);
    cyc(4'b0000, 1'b0);
    chk("zero_inv_none", 32'(bus2.o_RSP_INVALID), 32'h0);
    chk("zero_lat4_rsp_b", 32'(bus4.o_RSP_VALID), 32'h2);
    chk("zero_lat4_inv_b", 32'(bus4.o_RSP_INVALID), 32'h1);
    cyc(4'b0000, 1'b0);
    chk("zero_lat4_inv_c", 32'(bus4.o_RSP_INVALID), 32'h0);
    w[1] = 32'h2000_0002;
    load_words();

    // Hold with two conversions in flight; pointer sits at 3.
    cyc(4'b1001, 1'b0);
    chk("hold_pre_ready3", 32'(bus2.o_REQ_READY), 32'h8);
    cyc(4'b0001, 1'b0);
    chk("hold_pre_ready0", 32'(bus2.o_REQ_READY), 32'h1);
    cyc(4'b1101, 1'b1);
    chk("hold_ready_a", 32'(bus2.o_REQ_READY), 32'h0);
    chk("hold_cvt", bus2.o_CVT_WORD, 32'h0);
    chk("hold_rsp_a", 32'(bus2.o_RSP_VALID), 32'h8);
    chk("hold_busy", 32'(bus2.o_IDLE), 32'h0);
    cyc(4'b1101, 1'b1);
    chk("hold_ready_b", 32'(bus2.o_REQ_READY), 32'h0);
    chk("hold_rsp_b", 32'(bus2.o_RSP_VALID), 32'h1);
    chk("hold_rsp_word_b", bus2.o_RSP_WORD, w[0] ^ XK);
    cyc(4'b1101, 1'b1);
    chk("hold_rsp_none", 32'(bus2.o_RSP_VALID), 32'h0);
    chk("hold_idle", 32'(bus2.o_IDLE), 32'h1);
    cyc(4'b1101, 1'b0);
    chk("hold_release_ready", 32'(bus2.o_REQ_READY), 32'h4);
    repeat (5) cyc(4'b0000, 1'b0);
    chk("drain_idle4", 32'(bus4.o_IDLE), 32'h1);

    // Reset pulse right after two transfers discards both.
    cyc(4'b0011, 1'b0);
    chk("flush_ready0", 32'(bus2.o_REQ_READY), 32'h1);
    cyc(4'b0010, 1'b0);
    chk("flush_ready1", 32'(bus2.o_REQ_READY), 32'h2);
    cyc(4'b0000, 1'b0);
    i_RST_N = 1'b0;
    #1;
    chk("flush_rsp2_rst", 32'(bus2.o_RSP_VALID), 32'h0);
    chk("flush_idle2_rst", 32'(bus2.o_IDLE), 32'h1);
    chk("flush_idle4_rst", 32'(bus4.o_IDLE), 32'h1);
    cyc(4'b0000, 1'b0);
    chk("flush_rsp2_low", 32'(bus2.o_RSP_VALID), 32'h0);
    i_RST_N = 1'b1;
    cyc(4'b0000, 1'b0);
    chk("flush_rsp2_after", 32'(bus2.o_RSP_VALID), 32'h0);
    chk("flush_rsp4_a", 32'(bus4.o_RSP_VALID), 32'h0);
    cyc(4'b1010, 1'b0);
    chk("flush_rsp4_b", 32'(bus4.o_RSP_VALID), 32'h0);
    chk("flush_first_grant", 32'(bus2.o_REQ_READY), 32'h2);
    cyc(4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
